// File: rtl/main_mem_wait_state.sv
// rtl/main_mem_wait_state.sv - word RAM with programmable wait states, 8/16/32-bit lanes, range policy
// Optional feature macro: MAIN_MEM_WAIT_STATE_ALIGN_CHECK_EN (alignment and range fault reporting on err)
module main_mem_wait_state #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        data_inout_access_type,
    input  logic              we,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              wait_for_mem,
    output logic              err
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam int         NLANES   = DATA_W / 8;
    localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          size_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                err_q, err_d;
    logic                accept;
    logic                complete;

    logic [DATA_W-1:0]   mem_q [DEPTH_WORDS];

    // Address decode of the latched request
    logic                is_half;
    logic                is_byte;
    logic                in_range;
    logic                access_ok;
    logic [IDX_W-1:0]    mem_idx;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   rd_shift;
    logic [DATA_W-1:0]   rd_data;
    logic [NLANES-1:0]   lane_mask;
    logic [DATA_W-1:0]   lane_data;
    logic                mem_we;

    // State, counter, request latch and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            size_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            data_out_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            err_q      <= err_d;
            if (accept) begin
                addr_q  <= addr;
                size_q  <= data_inout_access_type;
                we_q    <= we;
                wdata_q <= data_in;
            end
        end
    end

    // Next state: accept in IDLE, count down wait states in BUSY
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        complete = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    state_d = S_BUSY;
                    cnt_d   = LAT_LAST;
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Lane decode, fault classification and read data steering
    always_comb begin
        is_half  = (size_q == 2'd1);
        is_byte  = (size_q == 2'd2);
        in_range = ((addr_q[ADDR_W-1:2] >> IDX_W) == '0);
        mem_idx  = addr_q[IDX_W+1:2];
        rd_word  = mem_q[mem_idx];
        rd_shift = rd_word >> {addr_q[1:0], 3'b000};
`ifdef MAIN_MEM_WAIT_STATE_ALIGN_CHECK_EN
        access_ok = in_range &&
                    !(is_half ? addr_q[0] : (!is_byte && (addr_q[1:0] != 2'b00)));
`else
        access_ok = in_range;
`endif
        if (is_half) begin
            lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{wdata_q[15:0]}};
            rd_data   = addr_q[1] ? {16'b0, rd_word[31:16]} : {16'b0, rd_word[15:0]};
        end else if (is_byte) begin
            lane_mask = 4'b0001 << addr_q[1:0];
            lane_data = {4{wdata_q[7:0]}};
            rd_data   = {24'b0, rd_shift[7:0]};
        end else begin
            lane_mask = 4'b1111;
            lane_data = wdata_q;
            rd_data   = rd_word;
        end
    end

    // Completion actions: commit write, capture read, raise fault pulse
    always_comb begin
        data_out_d = data_out_q;
        mem_we     = 1'b0;
`ifdef MAIN_MEM_WAIT_STATE_ALIGN_CHECK_EN
        err_d      = complete && !access_ok;
`else
        err_d      = 1'b0;
`endif
        if (complete) begin
            if (we_q) begin
                mem_we = access_ok;
            end else if (!in_range) begin
                data_out_d = '0;
            end else if (access_ok) begin
                data_out_d = rd_data;
            end
        end
    end

    // Memory array: byte-lane writes, contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < NLANES; k++) begin
                if (lane_mask[k]) begin
                    mem_q[mem_idx][8*k +: 8] <= lane_data[8*k +: 8];
                end
            end
        end
    end

    assign data_out     = data_out_q;
    assign wait_for_mem = (state_q == S_BUSY);
    assign err          = err_q;

endmodule
